// File: rtl/tree_node_store.sv
// Runtime-loadable node memory for the tree-ensemble engine: streaming tree loader
// with tail zero-fill and per-slot valid bitmap, plus a pipelined request/valid read port.
module tree_node_store #(
  parameter int NODE_WIDTH = 120,
  parameter int NUM_TREES  = 16,
  parameter int TREE_DEPTH = 512,
  parameter int TID_W      = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1,
  parameter int NADDR_W    = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_start,
  input  logic [TID_W-1:0]      ld_tree,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [NODE_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  ld_ovf,
  output logic [NUM_TREES-1:0]  tree_loaded,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [TID_W-1:0]      rd_tree,
  input  logic [NADDR_W-1:0]    rd_addr,
  output logic                  rd_valid,
  output logic [NODE_WIDTH-1:0] rd_data,
  output logic                  rd_err
);

  localparam int WORDS   = NUM_TREES * TREE_DEPTH;
  localparam int PADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [TID_W:0]       TREES_X  = (TID_W + 1)'(NUM_TREES);
  localparam logic [NADDR_W:0]     DEPTH_X  = (NADDR_W + 1)'(TREE_DEPTH);
  localparam logic [NADDR_W-1:0]   LAST_IDX = NADDR_W'(TREE_DEPTH - 1);
  localparam logic [PADDR_W-1:0]   DEPTH_P  = PADDR_W'(TREE_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, COMMIT} state_t;

  state_t                state;
  state_t                state_next;
  logic [TID_W-1:0]      cur_tree;
  logic [NADDR_W-1:0]    beat_idx;
  logic                  ovf_flag;

  logic                  start_ok;
  logic                  beat;
  logic                  at_last;
  logic                  wr_en;
  logic [PADDR_W-1:0]    wr_addr;
  logic [NODE_WIDTH-1:0] wr_data;

  logic                  rd_fire;
  logic                  rd_bad;
  logic                  tree_in;
  logic                  addr_in;
  logic [PADDR_W-1:0]    rd_paddr;
  logic [NODE_WIDTH-1:0] mem_q;
  logic                  s1_valid;
  logic                  s1_err;
  logic [NODE_WIDTH-1:0] s1_data;

  logic [NODE_WIDTH-1:0] mem [WORDS];

  assign start_ok = ld_start && ({1'b0, ld_tree} < TREES_X);
  assign at_last  = (beat_idx == LAST_IDX);
  assign beat     = (state == LOAD) && ld_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    if (beat && (ld_last || at_last)) state_next = at_last ? COMMIT : CLEAR;
      CLEAR:   if (at_last) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ld_ready = (state == LOAD);
  assign ld_busy  = (state != IDLE);
  assign ld_done  = (state == COMMIT);
  assign ld_ovf   = (state == COMMIT) && ovf_flag;

  // The slot's valid bit drops as soon as a reload starts so readers never see a half-written tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_tree    <= '0;
      beat_idx    <= '0;
      ovf_flag    <= 1'b0;
      tree_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            cur_tree              <= ld_tree;
            beat_idx              <= '0;
            ovf_flag              <= 1'b0;
            tree_loaded[ld_tree]  <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            if (!at_last)     beat_idx <= beat_idx + 1'b1;
            else if (!ld_last) ovf_flag <= 1'b1;
          end
        end
        CLEAR: begin
          if (!at_last) beat_idx <= beat_idx + 1'b1;
        end
        COMMIT: tree_loaded[cur_tree] <= 1'b1;
        default: ;
      endcase
    end
  end

  assign wr_en   = beat || (state == CLEAR);
  assign wr_data = (state == LOAD) ? ld_data : '0;
  assign wr_addr = PADDR_W'(cur_tree) * DEPTH_P + PADDR_W'(beat_idx);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the tree under load is blocked, which also rules out same-address write/read collisions.
  assign rd_ready = !((state != IDLE) && (rd_tree == cur_tree));
  assign rd_fire  = rd_req && rd_ready;
  assign tree_in  = ({1'b0, rd_tree} < TREES_X);
  assign addr_in  = ({1'b0, rd_addr} < DEPTH_X);
  assign rd_bad   = !(tree_in && addr_in && tree_loaded[rd_tree]);
  assign rd_paddr = PADDR_W'(rd_tree) * DEPTH_P + PADDR_W'(rd_addr);

  always_ff @(posedge clk) begin
    if (rd_fire && !rd_bad) mem_q <= mem[rd_paddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      s1_err   <= rd_fire && rd_bad;
    end
  end

  assign s1_data = (s1_valid && !s1_err) ? mem_q : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid <= 1'b0;
          rd_err   <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= s1_valid;
          rd_err   <= s1_err;
          rd_data  <= s1_data;
        end
      end
    end else begin : g_out_comb
      assign rd_valid = s1_valid;
      assign rd_err   = s1_err;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_tree_node_store.sv
// Bench for tree_node_store: two instances (OUT_REG=0 and OUT_REG=1) share stimulus;
// a per-instance queue holds predicted read results with their due cycle.
module tb_tree_node_store;

  localparam int NW = 120;
  localparam int NT = 4;
  localparam int TD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_start = 1'b0;
  logic [1:0]    ld_tree = '0;
  logic          ld_valid = 1'b0;
  logic [NW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          rd_req = 1'b0;
  logic [1:0]    rd_tree = '0;
  logic [2:0]    rd_addr = '0;

  logic          ld_ready0, ld_busy0, ld_done0, ld_ovf0, rd_ready0, rd_valid0, rd_err0;
  logic          ld_ready1, ld_busy1, ld_done1, ld_ovf1, rd_ready1, rd_valid1, rd_err1;
  logic [NT-1:0] tree_loaded0, tree_loaded1;
  logic [NW-1:0] rd_data0, rd_data1;

  typedef struct {
    logic [NW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [NW-1:0] model_mem [NT][TD];
  bit            model_loaded [NT];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  tree_node_store #(.NODE_WIDTH(NW), .NUM_TREES(NT), .TREE_DEPTH(TD), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_tree(ld_tree), .ld_valid(ld_valid),
    .ld_ready(ld_ready0), .ld_data(ld_data), .ld_last(ld_last), .ld_busy(ld_busy0),
    .ld_done(ld_done0), .ld_ovf(ld_ovf0), .tree_loaded(tree_loaded0), .rd_req(rd_req),
    .rd_ready(rd_ready0), .rd_tree(rd_tree), .rd_addr(rd_addr), .rd_valid(rd_valid0),
    .rd_data(rd_data0), .rd_err(rd_err0));

  tree_node_store #(.NODE_WIDTH(NW), .NUM_TREES(NT), .TREE_DEPTH(TD), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_tree(ld_tree), .ld_valid(ld_valid),
    .ld_ready(ld_ready1), .ld_data(ld_data), .ld_last(ld_last), .ld_busy(ld_busy1),
    .ld_done(ld_done1), .ld_ovf(ld_ovf1), .tree_loaded(tree_loaded1), .rd_req(rd_req),
    .rd_ready(rd_ready1), .rd_tree(rd_tree), .rd_addr(rd_addr), .rd_valid(rd_valid1),
    .rd_data(rd_data1), .rd_err(rd_err1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic [1:0] t, input logic [2:0] a, input int due);
    exp_t e;
    e.err  = !model_loaded[t];
    e.data = e.err ? '0 : model_mem[t][a];
    e.due  = due;
    return e;
  endfunction

  function automatic logic [NT-1:0] bitmap();
    logic [NT-1:0] b;
    for (int i = 0; i < NT; i++) b[i] = model_loaded[i];
    return b;
  endfunction

  // Scoreboard for the OUT_REG=0 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q0.delete();
    else begin
      if (rd_valid0) begin
        if (q0.size() == 0) checkOutput("rd0_unexpected", 128'(rd_valid0), 128'(0));
        else begin
          e = q0.pop_front();
          checkOutput("rd0_cycle", 128'(cyc), 128'(e.due));
          checkOutput("rd0_data", 128'(rd_data0), 128'(e.data));
          checkOutput("rd0_err", 128'(rd_err0), 128'(e.err));
        end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        checkOutput("rd0_missing", 128'(rd_valid0), 128'(1));
      end
      if (rd_req && rd_ready0) q0.push_back(predict(rd_tree, rd_addr, cyc + 1));
    end
  end

  // Scoreboard for the OUT_REG=1 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q1.delete();
    else begin
      if (rd_valid1) begin
        if (q1.size() == 0) checkOutput("rd1_unexpected", 128'(rd_valid1), 128'(0));
        else begin
          e = q1.pop_front();
          checkOutput("rd1_cycle", 128'(cyc), 128'(e.due));
          checkOutput("rd1_data", 128'(rd_data1), 128'(e.data));
          checkOutput("rd1_err", 128'(rd_err1), 128'(e.err));
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        checkOutput("rd1_missing", 128'(rd_valid1), 128'(1));
      end
      if (rd_req && rd_ready1) q1.push_back(predict(rd_tree, rd_addr, cyc + 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 10) begin
      tick();
      w++;
    end
    checkOutput("drain_q0", 128'(q0.size()), 128'(0));
    checkOutput("drain_q1", 128'(q1.size()), 128'(0));
  endtask

  task automatic drive_conc(input int conc, input int a);
    if (conc >= 0) begin
      rd_req  = 1'b1;
      rd_tree = 2'(conc);
      rd_addr = 3'(a % TD);
    end
  endtask

  task automatic check_conc_ready(input int conc, input int tid);
    if (conc >= 0) begin
      checkOutput("conc_rd_ready0", 128'(rd_ready0), 128'(conc != tid));
      checkOutput("conc_rd_ready1", 128'(rd_ready1), 128'(conc != tid));
    end
  endtask

  task automatic applyStimulus(input int t, input int a0, input int n);
    for (int i = 0; i < n; i++) begin
      rd_req  = 1'b1;
      rd_tree = 2'(t);
      rd_addr = 3'((a0 + i) % TD);
      tick();
    end
    rd_req = 1'b0;
    drain();
  endtask

  task automatic load_tree(input int tid, input int nbeats, input logic [NW-1:0] base,
                           input bit use_last, input int conc, input int glitch);
    ld_start = 1'b1;
    ld_tree  = 2'(tid);
    drive_conc(conc, 0);
    tick();
    ld_start = 1'b0;
    model_loaded[tid] = 1'b0;
    checkOutput("start_busy", 128'(ld_busy0), 128'(1));
    checkOutput("start_bit_clear", 128'(tree_loaded0[tid]), 128'(0));
    for (int i = 0; i < nbeats; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + NW'(i);
      ld_last  = use_last && (i == nbeats - 1);
      if (i == 1 && glitch >= 0) begin
        ld_start = 1'b1;
        ld_tree  = 2'(glitch);
      end
      model_mem[tid][i] = base + NW'(i);
      drive_conc(conc, i + 1);
      #1;
      checkOutput("beat_ready", 128'(ld_ready0), 128'(1));
      check_conc_ready(conc, tid);
      tick();
      ld_start = 1'b0;
    end
    ld_valid = 1'b1;
    ld_last  = 1'b0;
    ld_data  = '1;
    for (int i = nbeats; i < TD; i++) begin
      model_mem[tid][i] = '0;
      drive_conc(conc, i + 1);
      #1;
      checkOutput("clear_ready", 128'(ld_ready0), 128'(0));
      checkOutput("clear_done", 128'(ld_done0), 128'(0));
      check_conc_ready(conc, tid);
      tick();
    end
    drive_conc(conc, 0);
    #1;
    checkOutput("commit_done0", 128'(ld_done0), 128'(1));
    checkOutput("commit_done1", 128'(ld_done1), 128'(1));
    checkOutput("commit_ovf", 128'(ld_ovf0), 128'(nbeats == TD && !use_last));
    checkOutput("commit_ready", 128'(ld_ready0), 128'(0));
    check_conc_ready(conc, tid);
    tick();
    ld_valid = 1'b0;
    model_loaded[tid] = 1'b1;
    checkOutput("post_busy", 128'(ld_busy0), 128'(0));
    checkOutput("post_done", 128'(ld_done0), 128'(0));
    checkOutput("post_ovf", 128'(ld_ovf0), 128'(0));
    checkOutput("post_bitmap0", 128'(tree_loaded0), 128'(bitmap()));
    checkOutput("post_bitmap1", 128'(tree_loaded1), 128'(bitmap()));
    if (conc >= 0) begin
      drive_conc(conc, 1);
      #1;
      checkOutput("post_rd_ready", 128'(rd_ready0), 128'(1));
      tick();
    end
    rd_req = 1'b0;
    drain();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ld_ready"}, 128'(ld_ready0), 128'(0));
    checkOutput({tag, "_ld_busy"}, 128'(ld_busy0), 128'(0));
    checkOutput({tag, "_ld_done"}, 128'(ld_done0), 128'(0));
    checkOutput({tag, "_ld_ovf"}, 128'(ld_ovf0), 128'(0));
    checkOutput({tag, "_loaded0"}, 128'(tree_loaded0), 128'(0));
    checkOutput({tag, "_loaded1"}, 128'(tree_loaded1), 128'(0));
    checkOutput({tag, "_rd_valid0"}, 128'(rd_valid0), 128'(0));
    checkOutput({tag, "_rd_valid1"}, 128'(rd_valid1), 128'(0));
    checkOutput({tag, "_rd_data0"}, 128'(rd_data0), 128'(0));
    checkOutput({tag, "_rd_data1"}, 128'(rd_data1), 128'(0));
    checkOutput({tag, "_rd_err0"}, 128'(rd_err0), 128'(0));
    checkOutput({tag, "_rd_err1"}, 128'(rd_err1), 128'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int t = 0; t < NT; t++) begin
      model_loaded[t] = 1'b0;
      for (int a = 0; a < TD; a++) model_mem[t][a] = '0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Unloaded slot read returns an error with zero data
    applyStimulus(1, 0, 2);

    load_tree(2, 3, NW'('hA1), 1'b1, -1, -1);
    checkOutput("bitmap_0100", 128'(tree_loaded0), 128'(4'b0100));
    applyStimulus(2, 0, 8);

    // Overflow load of tree 0 with concurrent reads of tree 3 and a stray ld_start
    load_tree(0, 8, NW'('h100), 1'b0, 3, 2);

    // Reads of the tree under load stall until commit
    load_tree(1, 4, NW'('h200), 1'b1, 1, -1);
    applyStimulus(1, 0, 8);

    // Reload of tree 2 while tree 0 is read concurrently
    load_tree(2, 5, NW'('hB1), 1'b1, 0, -1);
    applyStimulus(2, 0, 8);
    applyStimulus(0, 0, 8);

    // Reset in the middle of a tree 3 load, with a read still in flight
    ld_start = 1'b1;
    ld_tree  = 2'd3;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = NW'('hDEAD);
    tick();
    ld_data  = NW'('hBEEF);
    rd_req   = 1'b1;
    rd_tree  = 2'd0;
    rd_addr  = 3'd0;
    tick();
    rd_req   = 1'b0;
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    for (int t = 0; t < NT; t++) model_loaded[t] = 1'b0;
    #1;
    check_reset_values("midload_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    load_tree(3, 8, NW'('h300), 1'b1, -1, -1);
    checkOutput("bitmap_1000", 128'(tree_loaded0), 128'(4'b1000));
    applyStimulus(3, 0, 8);
    applyStimulus(2, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tree_node_store.md
# tree_node_store

Parametrised, runtime-loadable node memory for the tree-ensemble inference engine. It is the successor to the per-tree fixed ROMs. One instance holds NUM_TREES trees of TREE_DEPTH nodes each in a single simple-dual-port array. Trees are loaded over a streaming handshake; an internal FSM zero-fills each tree's unused tail, and the block tracks which trees are valid. The traversal FSMs read nodes through a request/valid port whose latency is configurable.

## Interface
- NODE_WIDTH, 120, bits per packed node word (format opaque to this block)
- NUM_TREES, 16, number of tree slots
- TREE_DEPTH, 512, node slots per tree; need not be a power of two
- TID_W, $clog2(NUM_TREES), tree-id width
- NADDR_W, $clog2(TREE_DEPTH), node-address width
- OUT_REG, 0, 1 adds an output register stage to the read path

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_start  in  1  pulse: begin loading tree ld_tree
- ld_tree  in  TID_W  target slot; sampled with ld_start
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid & ld_ready
- ld_data  in  NODE_WIDTH  node word
- ld_last  in  1  final beat of this tree
- ld_busy  out  1  load FSM not IDLE
- ld_done  out  1  one-cycle pulse: tree committed
- ld_ovf  out  1  one-cycle pulse with ld_done: depth reached without ld_last
- tree_loaded  out  NUM_TREES  per-slot valid bitmap
- rd_req  in  1  read request
- rd_ready  out  1  request accepted when rd_req & rd_ready
- rd_tree  in  TID_W  tree id
- rd_addr  in  NADDR_W  node index within tree
- rd_valid  out  1  rd_data/rd_err valid
- rd_data  out  NODE_WIDTH  node word
- rd_err  out  1  slot unloaded, tree id ≥ NUM_TREES, or rd_addr ≥ TREE_DEPTH

## Operation
- Physical address: tree*TREE_DEPTH + addr. The array is NUM_TREES*TREE_DEPTH words and is not reset.
- Load FSM states: IDLE, LOAD, CLEAR, COMMIT.
- IDLE: on ld_start with ld_tree < NUM_TREES:
  - clear tree_loaded[ld_tree];
  - latch the tree id;
  - zero the beat counter;
  - go to LOAD.
  - ld_start with an out-of-range tree id is ignored. ld_start outside IDLE is ignored.
- LOAD: ld_ready=1. Each accepted beat writes ld_data at the current counter value, then the counter increments.
  - Beat with ld_last, or the beat at index TREE_DEPTH-1: if the index < TREE_DEPTH-1, go to CLEAR starting at index+1; otherwise go to COMMIT.
  - ld_ovf is set when the index-(TREE_DEPTH-1) beat lacks ld_last.
- CLEAR: ld_ready=0. Writes zero, one word per cycle, through index TREE_DEPTH-1, then goes to COMMIT.
- COMMIT (1 cycle): set tree_loaded[id], pulse ld_done (and ld_ovf if flagged), return to IDLE.
- Read port:
  - rd_ready = 0 only when rd_tree equals the tree currently being loaded (LOAD/CLEAR/COMMIT); otherwise rd_ready = 1.
  - A read of any other tree proceeds concurrently with a load.
  - An accepted read with an error condition returns rd_data=0 and rd_err=1. It never reads out of bounds.
- ld_busy = (state != IDLE).

## Timing
- Reset values: state IDLE, ld_ready=0, ld_busy=0, ld_done=0, ld_ovf=0, tree_loaded=0, rd_valid=0, rd_data=0, rd_err=0.
- Read latency: rd_valid is asserted 1+OUT_REG cycles after acceptance. The read path is fully pipelined (one request per cycle) with no backpressure on output.
- Write→read ordering: a read accepted in the cycle after COMMIT returns committed data. There is no same-cycle write/read collision, because the loading tree is blocked by rd_ready.
- Load throughput: one beat per cycle. Total load time = beats + (TREE_DEPTH-beats) clear cycles + 1 commit cycle + 1 for ld_start.
- Reset asserted mid-load: FSM returns to IDLE and the slot stays unloaded. In-flight reads are dropped (rd_valid=0).
- ld_valid while ld_ready=0 is not consumed. The source holds the beat.

## Test plan
(Bench parameters: NUM_TREES=4, TREE_DEPTH=8, NODE_WIDTH=120.)
- Load tree 2 with 3 beats (values 0xA1, 0xA2, 0xA3, last on third) -> 5 CLEAR cycles, then ld_done, tree_loaded=4'b0100. Reads of tree 2 addr 0..7 return A1, A2, A3, then 0 ×5, rd_err=0.
- OUT_REG=0 and OUT_REG=1: back-to-back reads on consecutive cycles -> rd_valid at +1 / +2 cycles, one result per cycle, in order.
- Read of tree 1 while tree 1 is unloaded -> rd_data=0, rd_err=1. Read of tree 3 addr 0 during tree 0 load -> rd_ready=1, serviced. Read of tree 0 during tree 0 load -> rd_ready=0 until COMMIT has completed.
- 8 beats without ld_last to tree 0 -> no CLEAR, ld_done and ld_ovf pulse together, ld_ready=0 after the 8th beat.
- ld_start during LOAD -> ignored, tree_loaded unchanged. Reload of a loaded tree 2 -> bit 2 clears at start and resets on COMMIT with the new data.
- rst_n low after 2 beats of a tree 3 load -> all outputs at reset values, tree_loaded=0. A subsequent full load of tree 3 succeeds.
